// File: rtl/ble_pkg.sv
// Shared constants and state encodings for the BLE UART transmit path.
package ble_pkg;

    localparam logic [7:0] BLE_NEWLINE  = 8'h0A;
    localparam logic [7:0] BLE_NL_SUBST = 8'h0B;
    localparam int         BLE_CLK_FREQ = 100_000_000;
    localparam int         BLE_BAUD     = 115_200;

    typedef enum logic [1:0] {IDLE, FIELD, NEWLINE, DRAIN} tx_frame_state_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_tx_state_t;

    // A payload byte must never look like the packet terminator to the receiver.
    function automatic logic [7:0] nl_subst(input logic [7:0] b);
        return (b == BLE_NEWLINE) ? BLE_NL_SUBST : b;
    endfunction

endpackage

// File: rtl/ble_packet_tx_uart_tx.sv
// 8N1 serializer, LSB first; ready also rises in the last stop-bit cycle so bytes chain without gaps.
module uart_tx
    import ble_pkg::*;
#(
    parameter int CLK_FREQ = BLE_CLK_FREQ,
    parameter int BAUD     = BLE_BAUD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       txd
);
    // state   | meaning
    // S_IDLE  | line idle high, waiting for a byte
    // S_START | driving the start bit (low)
    // S_DATA  | shifting out data[0..7]
    // S_STOP  | driving the stop bit (high)

    localparam int CLKS_PER_BIT        = CLK_FREQ / BAUD;
    localparam int CW                  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LOAD = CW'(CLKS_PER_BIT - 1);

    uart_tx_state_t r_state, w_state_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [2:0]     r_bit, w_bit_nxt;
    logic [7:0]     r_shift, w_shift_nxt;
    logic           w_bit_end;

    assign w_bit_end = (r_cnt == '0);
    assign ready     = (r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        txd         = 1'b1;
        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_bit_end ? BIT_LOAD : (r_cnt - CW'(1));
        end
        case (r_state)
            S_START: begin
                txd = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                txd = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) w_state_nxt = S_IDLE;
            end
            default: ;
        endcase
        if (start && ready) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = BIT_LOAD;
            w_shift_nxt = data;
        end
    end

endmodule

// File: rtl/ble_packet_tx.sv
// Frames a snapshot of NUM_FIELDS bytes plus a newline terminator onto the BLE UART line.
module ble_packet_tx
    import ble_pkg::*;
#(
    parameter int CLK_FREQ   = BLE_CLK_FREQ,
    parameter int BAUD       = BLE_BAUD,
    parameter int NUM_FIELDS = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_FIELDS-1:0][7:0] fields,
    input  logic                       send,
    output logic                       txd,
    output logic                       busy,
    output logic                       done,
    output logic                       req_dropped
);
    // state   | meaning
    // IDLE    | waiting for send; byte 0 is handed to the serializer on acceptance
    // FIELD   | issuing snapshot byte r_idx
    // NEWLINE | issuing the 0x0A terminator
    // DRAIN   | waiting for the terminator's stop bit to finish

    localparam logic [7:0] LAST_IDX = 8'(NUM_FIELDS - 1);

    tx_frame_state_t            r_state, w_state_nxt;
    logic [NUM_FIELDS-1:0][7:0] r_snap;
    logic [7:0]                 r_idx, w_idx_nxt;
    logic                       r_done;
    logic                       w_ready, w_start, w_accept;
    logic [7:0]                 w_field, w_byte;

    assign busy        = (r_state != IDLE);
    assign w_accept    = send && !busy;
    assign req_dropped = send && busy;
    assign done        = r_done;

    always_comb begin
        w_field = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (r_idx == 8'(i)) w_field = r_snap[i];
        end
    end

    // Byte 0 comes straight from the inputs so the start bit begins on the acceptance edge.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_start     = 1'b0;
        w_byte      = nl_subst(w_field);
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_start     = 1'b1;
                    w_byte      = nl_subst(fields[0]);
                    w_idx_nxt   = 8'd1;
                    w_state_nxt = (NUM_FIELDS == 1) ? NEWLINE : FIELD;
                end
            end
            FIELD: begin
                w_start = 1'b1;
                if (w_ready) begin
                    w_idx_nxt = r_idx + 8'd1;
                    if (r_idx == LAST_IDX) w_state_nxt = NEWLINE;
                end
            end
            NEWLINE: begin
                w_start = 1'b1;
                w_byte  = BLE_NEWLINE;
                if (w_ready) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_snap  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_done  <= (r_state == DRAIN) && w_ready;
            if (w_accept) r_snap <= fields;
        end
    end

    uart_tx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_uart_tx (
        .clk   (clk),
        .rst   (rst),
        .data  (w_byte),
        .start (w_start),
        .ready (w_ready),
        .txd   (txd)
    );

endmodule

// File: tb/tb_ble_packet_tx.sv
// Scoreboarded bench for ble_packet_tx: expected bytes are queued on send and checked by a UART decoder.
module tb_ble_packet_tx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 125_000;
    localparam int NF       = 10;
    localparam int CPB      = 8;
    localparam int BYTE_CYC = 10 * CPB;
    localparam int FRAME    = (NF + 1) * BYTE_CYC;

    logic               clk = 1'b0;
    logic               rst;
    logic               send;
    logic [NF-1:0][7:0] fields;
    logic               txd, busy, done, req_dropped;

    ble_packet_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .NUM_FIELDS (NF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fields      (fields),
        .send        (send),
        .txd         (txd),
        .busy        (busy),
        .done        (done),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         drop_cnt = 0;
    int         done_cnt = 0;

    always @(negedge clk) begin
        if (!rst && req_dropped === 1'b1) drop_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    // UART decoder: samples each bit at its centre and pops the scoreboard on the stop bit.
    bit         m_act = 1'b0;
    bit         m_ferr;
    int         m_start, m_pos, m_bit;
    logic [7:0] m_byte, m_exp;
    always @(negedge clk) begin
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (txd === 1'b0) begin
                m_act   = 1'b1;
                m_start = cyc;
                m_ferr  = 1'b0;
                m_byte  = '0;
                start_q.push_back(cyc);
            end
        end else begin
            m_pos = cyc - m_start;
            if (m_pos % CPB == CPB / 2) begin
                m_bit = m_pos / CPB;
                if (m_bit == 0) begin
                    if (txd !== 1'b0) m_ferr = 1'b1;
                end else if (m_bit <= 8) begin
                    m_byte[3'(m_bit - 1)] = txd;
                end else begin
                    if (txd !== 1'b1) m_ferr = 1'b1;
                    m_act = 1'b0;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL rx_byte: got %02h at cycle %0d, expected no byte", m_byte, cyc);
                    end else begin
                        m_exp = exp_q.pop_front();
                        if (m_ferr || m_byte !== m_exp) begin
                            n_err++;
                            $display("FAIL rx_byte: got %02h (framing_err=%0d), expected %02h", m_byte, m_ferr, m_exp);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [NF-1:0][7:0] f);
        for (int i = 0; i < NF; i++) exp_q.push_back((f[i] == 8'h0A) ? 8'h0B : f[i]);
        exp_q.push_back(8'h0A);
    endtask

    task automatic send_frame(input logic [NF-1:0][7:0] f, output int acc);
        fields = f;
        push_frame(f);
        send = 1'b1;
        tick();
        acc  = cyc;
        send = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int dcyc, output bit ok);
        ok   = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            if (done === 1'b1) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; send = 1'b0; fields = '0;
        tick(); tick();
        n_chk++; if (txd !== 1'b1) begin n_err++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_chk++; if (req_dropped !== 1'b0) begin n_err++; $display("FAIL reset_req_dropped: got %b expected 0", req_dropped); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_frame();
        logic [7:0]         v [NF];
        logic [NF-1:0][7:0] f;
        int                 acc, dc, s0;
        bit                 ok, sp_ok;
        v = '{8'h01, 8'h00, 8'h7F, 8'h80, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'hFF};
        for (int i = 0; i < NF; i++) f[i] = v[i];
        s0 = start_q.size();
        send_frame(f, acc);
        n_chk++; if (txd !== 1'b0) begin n_err++; $display("FAIL single_latency_txd: got %b expected 0", txd); end
        n_chk++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b expected 1", busy); end
        wait_done(FRAME + 50, dc, ok);
        n_chk++; if (!ok || dc != acc + FRAME) begin n_err++; $display("FAIL single_done_time: got %0d expected %0d", dc - acc, FRAME); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_busy_at_done: got %b expected 0", busy); end
        tick();
        n_chk++; if (done !== 1'b0) begin n_err++; $display("FAIL single_done_width: got %b expected 0", done); end
        sp_ok = (start_q.size() == s0 + NF + 1);
        if (sp_ok) for (int k = 0; k <= NF; k++) if (start_q[s0 + k] != acc + k * BYTE_CYC) sp_ok = 1'b0;
        n_chk++; if (!sp_ok) begin n_err++; $display("FAIL single_byte_spacing: got %0d starts expected %0d at %0d-cycle pitch", start_q.size() - s0, NF + 1, BYTE_CYC); end
        n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_bytes_left: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_substitution();
        logic [NF-1:0][7:0] f;
        int                 acc, dc;
        bit                 ok;
        for (int i = 0; i < NF; i++) f[i] = 8'(8'h30 + i);
        f[3] = 8'h0A; f[7] = 8'h0A; f[5] = 8'h0B;
        send_frame(f, acc);
        wait_done(FRAME + 50, dc, ok);
        n_chk++; if (!ok || dc != acc + FRAME) begin n_err++; $display("FAIL subst_done_time: got %0d expected %0d", dc - acc, FRAME); end
        n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL subst_bytes_left: got %0d expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_snapshot_drop();
        logic [NF-1:0][7:0] f;
        int                 acc, dc, s0, d0;
        bit                 ok;
        for (int i = 0; i < NF; i++) f[i] = 8'(8'h40 + i);
        s0 = start_q.size();
        d0 = drop_cnt;
        send_frame(f, acc);
        for (int i = 0; i < FRAME && cyc < acc + 4 * BYTE_CYC + 20; i++) tick();
        fields = ~f;
        send   = 1'b1;
        #1;
        n_chk++; if (req_dropped !== 1'b1) begin n_err++; $display("FAIL drop_pulse: got %b expected 1", req_dropped); end
        tick();
        send = 1'b0;
        wait_done(FRAME + 50, dc, ok);
        n_chk++; if (!ok || dc != acc + FRAME) begin n_err++; $display("FAIL drop_done_time: got %0d expected %0d", dc - acc, FRAME); end
        n_chk++; if (drop_cnt - d0 != 1) begin n_err++; $display("FAIL drop_count: got %0d expected 1", drop_cnt - d0); end
        for (int i = 0; i < 3 * BYTE_CYC; i++) tick();
        n_chk++; if (start_q.size() != s0 + NF + 1) begin n_err++; $display("FAIL drop_no_second_frame: got %0d starts expected %0d", start_q.size() - s0, NF + 1); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL drop_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [NF-1:0][7:0] f1, f2;
        int                 acc1, acc2, dc1, dc2, s0, d0;
        bit                 ok;
        for (int i = 0; i < NF; i++) begin
            f1[i] = 8'(8'hA0 + i);
            f2[i] = 8'(8'hC3 - i);
        end
        s0 = start_q.size();
        d0 = drop_cnt;
        send_frame(f1, acc1);
        wait_done(FRAME + 50, dc1, ok);
        n_chk++; if (!ok) begin n_err++; $display("FAIL b2b_first_done: got timeout expected done"); end
        send_frame(f2, acc2);
        wait_done(FRAME + 50, dc2, ok);
        n_chk++; if (!ok || dc2 != acc2 + FRAME) begin n_err++; $display("FAIL b2b_second_done_time: got %0d expected %0d", dc2 - acc2, FRAME); end
        n_chk++;
        if (start_q.size() < s0 + NF + 2 || start_q[s0 + NF + 1] != dc1 + 1) begin
            n_err++;
            $display("FAIL b2b_gap: second frame start got %0d expected %0d", (start_q.size() >= s0 + NF + 2) ? start_q[s0 + NF + 1] : -1, dc1 + 1);
        end
        n_chk++; if (drop_cnt != d0) begin n_err++; $display("FAIL b2b_no_drop: got %0d expected 0", drop_cnt - d0); end
        n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_bytes_left: got %0d expected 0", exp_q.size()); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [NF-1:0][7:0] f;
        int                 acc, dc, dn0;
        bit                 ok;
        for (int i = 0; i < NF; i++) f[i] = 8'(8'h55 ^ (i * 8'h11));
        dn0 = done_cnt;
        send_frame(f, acc);
        for (int i = 0; i < FRAME && cyc < acc + 2 * BYTE_CYC + 4 * CPB + 2; i++) tick();
        rst = 1'b1;
        #1;
        n_chk++; if (txd !== 1'b1) begin n_err++; $display("FAIL rst_mid_txd: got %b expected 1", txd); end
        n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        exp_q.delete();
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        n_chk++; if (done_cnt != dn0) begin n_err++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", done_cnt - dn0); end
        for (int i = 0; i < NF; i++) f[i] = 8'(8'h90 + 3 * i);
        send_frame(f, acc);
        wait_done(FRAME + 50, dc, ok);
        n_chk++; if (!ok || dc != acc + FRAME) begin n_err++; $display("FAIL rst_mid_refresh_done: got %0d expected %0d", dc - acc, FRAME); end
        n_chk++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rst_mid_bytes_left: got %0d expected 0", exp_q.size()); end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; send = 1'b0; fields = '0;
        test_reset();
        test_single_frame();
        test_substitution();
        test_snapshot_drop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
